// File: rtl/ll2_hdecim.sv
// ll2_hdecim: [1 2 1]/4 horizontal half-band decimator on LL2 actor ports, one output per input pair.
// Define LL2_HDECIM_ROUND_EN for round-half-up; the default build truncates.
module ll2_hdecim #(
    parameter int IMG_WIDTH = 512,
    parameter int DATA_W    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic              Out1_SEND,
    output logic [15:0]       Out1_COUNT,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK
);
    localparam int CW = $clog2(IMG_WIDTH);
`ifdef LL2_HDECIM_ROUND_EN
    localparam logic [DATA_W+1:0] RND = 2;
`else
    localparam logic [DATA_W+1:0] RND = 0;
`endif
    typedef enum logic [1:0] {S_EVEN, S_ODD, S_EMIT} state_t;
    state_t            state, state_nx;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] prev, even, out_q, filt;
    logic              unused_ok;
    assign unused_ok = ^{In1_COUNT, Out1_ACK};
    assign filt = DATA_W'(({2'b0, prev} + {1'b0, even, 1'b0} + {2'b0, In1_DATA} + RND) >> 2);
    assign Out1_DATA  = out_q;
    assign Out1_COUNT = {15'b0, Out1_SEND};
    always_comb begin
        state_nx  = state;
        In1_ACK   = 1'b0;
        Out1_SEND = 1'b0;
        if (state == S_EMIT) begin
            Out1_SEND = Out1_RDY;
            state_nx  = Out1_RDY ? S_EVEN : S_EMIT;
        end else begin
            In1_ACK = In1_SEND & RESET;
            if (In1_SEND) state_nx = (state == S_EVEN) ? S_ODD : S_EMIT;
        end
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_EVEN;
        else        state <= state_nx;
    end
    // prev carries x[2k-1] into the next pair; at col 0 it replicates x0 instead
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            col   <= '0;
            prev  <= '0;
            even  <= '0;
            out_q <= '0;
        end else if (In1_ACK) begin
            if (state == S_EVEN) begin
                even <= In1_DATA;
                if (col == '0) prev <= In1_DATA;
                col <= col + 1'b1;
            end else begin
                out_q <= filt;
                prev  <= In1_DATA;
                col   <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ll2_hdecim.sv
// tb_ll2_hdecim: randomized row stream against a per-row [1 2 1]/4 decimation model with handshake tracking.
module tb_ll2_hdecim;
    localparam int W = 8;
`ifdef LL2_HDECIM_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif
    logic        CLK = 0, RESET = 0;
    logic [15:0] In1_DATA = 0, In1_COUNT = 0;
    logic        In1_SEND = 0, Out1_RDY = 0, Out1_ACK = 0;
    logic        In1_ACK, Out1_SEND;
    logic [15:0] Out1_DATA, Out1_COUNT;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] pix[$];
    logic [15:0] exp_q[$];
    logic [15:0] r [W];

    ll2_hdecim #(.IMG_WIDTH(W), .DATA_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
        .In1_ACK(In1_ACK), .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_COUNT(Out1_COUNT),
        .Out1_RDY(Out1_RDY), .Out1_ACK(Out1_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // each output k of a row is the [1 2 1] tap centred on x[2k], with x[-1] taken as x[0]
    task automatic add_row(input logic [15:0] row [W]);
        for (int k = 0; k < W / 2; k++) begin
            int a = (k == 0) ? int'(row[0]) : int'(row[2*k-1]);
            exp_q.push_back(16'((a + 2 * int'(row[2*k]) + int'(row[2*k+1]) + RND) >> 2));
        end
        for (int i = 0; i < W; i++) pix.push_back(row[i]);
    endtask

    task automatic run(input int max_cyc, input bit rand_hs);
        bit pend = 0;
        int acc = 0;
        for (int c = 0; c < max_cyc && (pix.size() > 0 || exp_q.size() > 0); c++) begin
            In1_SEND = pix.size() > 0 && (!rand_hs || $urandom_range(0, 3) != 0);
            In1_DATA = In1_SEND ? pix[0] : 16'($urandom);
            Out1_RDY = !rand_hs || $urandom_range(0, 2) != 0;
            @(negedge CLK);
            check("ack", int'(In1_ACK), int'(In1_SEND && !pend));
            check("send", int'(Out1_SEND), int'(pend && Out1_RDY));
            check("count", int'(Out1_COUNT), int'(Out1_SEND));
            if (Out1_SEND) begin
                if (exp_q.size() == 0) check("extra_out", 1, 0);
                else check("out", int'(Out1_DATA), int'(exp_q.pop_front()));
                pend = 0;
            end
            if (In1_ACK) begin
                void'(pix.pop_front());
                acc++;
                if (acc % 2 == 0) pend = 1;
            end
            @(posedge CLK); #1;
        end
        check("drained", pix.size() + exp_q.size(), 0);
        In1_SEND = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", int'(In1_ACK), 0);
        check("rst_send", int'(Out1_SEND), 0);
        check("rst_data", int'(Out1_DATA), 0);
        check("rst_count", int'(Out1_COUNT), 0);
    endtask

    initial begin
        In1_SEND = 1; Out1_RDY = 1; In1_DATA = 16'h1234;
        repeat (2) begin @(negedge CLK); check_reset_outputs(); end
        @(posedge CLK); #1;
        RESET = 1; In1_SEND = 0;
        @(posedge CLK); #1;
        for (int i = 0; i < W; i++) r[i] = 16'(i);
        add_row(r); run(200, 0);
        for (int i = 0; i < W; i++) r[i] = 16'hFFFF;
        add_row(r); run(200, 0);
        for (int i = 0; i < W; i++) r[i] = (i == 0) ? 16'd0 : 16'd2;
        add_row(r); run(200, 1);
        // stall: hold Out1_RDY low with a pair pending
        for (int i = 0; i < W; i++) r[i] = 16'(10 * (i + 1));
        add_row(r);
        Out1_RDY = 0;
        for (int i = 0; i < 2; i++) begin
            In1_SEND = 1; In1_DATA = pix[0];
            @(negedge CLK); check("stall_in_ack", int'(In1_ACK), 1);
            @(posedge CLK); #1; void'(pix.pop_front());
        end
        In1_SEND = 1; In1_DATA = pix[0];
        repeat (10) begin
            @(negedge CLK);
            check("stall_ack", int'(In1_ACK), 0);
            check("stall_send", int'(Out1_SEND), 0);
            check("stall_data", int'(Out1_DATA), int'(exp_q[0]));
        end
        @(posedge CLK); #1; Out1_RDY = 1;
        @(negedge CLK);
        check("stall_release", int'(Out1_SEND), 1);
        check("stall_out", int'(Out1_DATA), int'(exp_q.pop_front()));
        @(posedge CLK); #1;
        run(200, 0);
        for (int i = 0; i < W; i++) r[i] = 16'd100;
        add_row(r);
        for (int i = 0; i < W; i++) r[i] = 16'd0;
        add_row(r); run(400, 1);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < W; i++) r[i] = 16'($urandom);
            add_row(r);
        end
        run(2000, 1);
        // reset after three tokens of a row
        for (int i = 0; i < W; i++) r[i] = 16'(i + 50);
        add_row(r);
        Out1_RDY = 1;
        begin
            int acks = 0;
            for (int c = 0; c < 20 && acks < 3; c++) begin
                In1_SEND = 1; In1_DATA = pix[0];
                @(negedge CLK);
                if (Out1_SEND) check("pre_rst_out", int'(Out1_DATA), int'(exp_q.pop_front()));
                if (In1_ACK) begin void'(pix.pop_front()); acks++; end
                @(posedge CLK); #1;
            end
            check("pre_rst_acks", acks, 3);
        end
        RESET = 0; In1_SEND = 1; In1_DATA = pix[0];
        #1 check_reset_outputs();
        repeat (2) begin @(negedge CLK); check_reset_outputs(); end
        @(posedge CLK); #1;
        RESET = 1; In1_SEND = 0;
        pix.delete(); exp_q.delete();
        @(posedge CLK); #1;
        for (int i = 0; i < W; i++) r[i] = 16'(i);
        add_row(r); run(200, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
